wb_stage: RTL and testbench

- Write-back stage of the MIPS pipeline; the write end of the 32x32 register file that the ID stage reads.
- Accepts one retiring instruction per cycle from the MEM stage.
- Selects the destination register, sign- or zero-extends load data, and drives a registered register-file write port.
- Owns the HI/LO architectural registers and a retired-instruction counter.

---
 rtl/mips_defs.sv | 75 +++++++
 rtl/load_ext.sv | 39 +++
 rtl/wb_stage.sv | 148 ++++++++++++++
 tb/tb_wb_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared MIPS opcode/funct encodings and helpers, used by the ID and WB stages.
package mips_defs;

  localparam int unsigned REGFILE_SIZE = 32;

  // Primary opcodes (Ins[31:26])
  localparam logic [5:0] R_FORM = 6'h00;
  localparam logic [5:0] J      = 6'h02;
  localparam logic [5:0] JAL    = 6'h03;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] ADDIU  = 6'h09;
  localparam logic [5:0] SLTI   = 6'h0A;
  localparam logic [5:0] SLTIU  = 6'h0B;
  localparam logic [5:0] ANDI   = 6'h0C;
  localparam logic [5:0] ORI    = 6'h0D;
  localparam logic [5:0] XORI   = 6'h0E;
  localparam logic [5:0] LUI    = 6'h0F;
  localparam logic [5:0] LB     = 6'h20;
  localparam logic [5:0] LH     = 6'h21;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] LBU    = 6'h24;
  localparam logic [5:0] LHU    = 6'h25;
  localparam logic [5:0] SB     = 6'h28;
  localparam logic [5:0] SH     = 6'h29;
  localparam logic [5:0] SW     = 6'h2B;

  // R-form function codes (Ins[5:0])
  localparam logic [5:0] SLL   = 6'h00;
  localparam logic [5:0] SRL   = 6'h02;
  localparam logic [5:0] SRA   = 6'h03;
  localparam logic [5:0] SLLV  = 6'h04;
  localparam logic [5:0] SRLV  = 6'h06;
  localparam logic [5:0] SRAV  = 6'h07;
  localparam logic [5:0] JR    = 6'h08;
  localparam logic [5:0] JALR  = 6'h09;
  localparam logic [5:0] MFHI  = 6'h10;
  localparam logic [5:0] MTHI  = 6'h11;
  localparam logic [5:0] MFLO  = 6'h12;
  localparam logic [5:0] MTLO  = 6'h13;
  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIV   = 6'h1A;
  localparam logic [5:0] DIVU  = 6'h1B;
  localparam logic [5:0] ADD   = 6'h20;
  localparam logic [5:0] ADDU  = 6'h21;
  localparam logic [5:0] SUB   = 6'h22;
  localparam logic [5:0] SUBU  = 6'h23;
  localparam logic [5:0] AND   = 6'h24;
  localparam logic [5:0] OR    = 6'h25;
  localparam logic [5:0] XOR   = 6'h26;
  localparam logic [5:0] NOR   = 6'h27;
  localparam logic [5:0] SLT   = 6'h2A;
  localparam logic [5:0] SLTU  = 6'h2B;

  // Source of the register-file write data
  typedef enum logic [2:0] {
    WbNone,
    WbAlu,
    WbLink,
    WbHi,
    WbLo,
    WbLoad
  } wb_src_e;

  function automatic logic is_alu_funct(input logic [5:0] funct);
    case (funct)
      SLL, SRL, SRA, SLLV, SRLV, SRAV,
      ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_ext.sv
// Big-endian byte/halfword select and sign/zero extension for load results.
module load_ext
  import mips_defs::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] MemData,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    unique case (addr_lo)
      2'd0: byte_sel = MemData[31:24];
      2'd1: byte_sel = MemData[23:16];
      2'd2: byte_sel = MemData[15:8];
      2'd3: byte_sel = MemData[7:0];
      default: byte_sel = 8'h00;
    endcase
  end

  // Misaligned halfword/word accesses simply drop the low address bits
  assign half_sel = addr_lo[1] ? MemData[15:0] : MemData[31:16];

  always_comb begin
    load_data = MemData;
    case (op)
      LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     load_data = {24'h0, byte_sel};
      LH:      load_data = {{16{half_sel[15]}}, half_sel};
      LHU:     load_data = {16'h0, half_sel};
      default: load_data = MemData;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: register-file write port, HI/LO registers and a
// retired-instruction counter.
module wb_stage
  import mips_defs::*;
#(
  parameter logic [4:0]  LINK_REG = 5'd31,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      Ins,
  input  logic [31:0]      PC4,
  input  logic [31:0]      AluRes,
  input  logic [31:0]      MemData,
  input  logic [63:0]      MulRes,
  input  logic             wb_stall,
  output logic             wb_we,
  output logic [4:0]       wb_waddr,
  output logic [31:0]      wb_wdata,
  output logic [31:0]      Hi,
  output logic [31:0]      Lo,
  output logic [CNT_W-1:0] retired
);

  logic [5:0]  op, funct;
  logic [4:0]  rt, rd;
  logic        accept;

  wb_src_e     src;
  logic [4:0]  waddr_d;
  logic [31:0] wdata_d;
  logic        we_d;
  logic        hi_we, lo_we, mul_we;
  logic [31:0] load_data;

  logic             we_q;
  logic [4:0]       waddr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      hi_q, lo_q;
  logic [CNT_W-1:0] retired_q;

  assign op     = Ins[31:26];
  assign funct  = Ins[5:0];
  assign rt     = Ins[20:16];
  assign rd     = Ins[15:11];
  assign in_ready = !wb_stall;
  assign accept   = in_valid && in_ready;

  // rs and shamt are consumed by earlier stages only
  logic unused_ins;
  assign unused_ins = ^{Ins[25:21], Ins[10:6]};

  load_ext u_load_ext (
    .op        (op),
    .addr_lo   (AluRes[1:0]),
    .MemData   (MemData),
    .load_data (load_data)
  );

  always_comb begin
    src     = WbNone;
    waddr_d = rd;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    mul_we  = 1'b0;
    case (op)
      R_FORM: begin
        if (is_alu_funct(funct)) begin
          src = WbAlu;
        end else begin
          case (funct)
            JALR:                   src    = WbLink;
            MFHI:                   src    = WbHi;
            MFLO:                   src    = WbLo;
            MTHI:                   hi_we  = 1'b1;
            MTLO:                   lo_we  = 1'b1;
            MULT, MULTU, DIV, DIVU: mul_we = 1'b1;
            default:                src    = WbNone;
          endcase
        end
      end
      ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI: begin
        src     = WbAlu;
        waddr_d = rt;
      end
      JAL: begin
        src     = WbLink;
        waddr_d = LINK_REG;
      end
      LB, LH, LW, LBU, LHU: begin
        src     = WbLoad;
        waddr_d = rt;
      end
      default: src = WbNone;
    endcase
  end

  always_comb begin
    wdata_d = AluRes;
    unique case (src)
      WbAlu:   wdata_d = AluRes;
      WbLink:  wdata_d = PC4;
      WbHi:    wdata_d = hi_q;
      WbLo:    wdata_d = lo_q;
      WbLoad:  wdata_d = load_data;
      default: wdata_d = AluRes;
    endcase
  end

  // $0 is hardwired: suppress the write but keep address/data moving
  assign we_d = (src != WbNone) && (waddr_d != 5'd0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      we_q      <= 1'b0;
      waddr_q   <= 5'd0;
      wdata_q   <= 32'h0;
      hi_q      <= 32'h0;
      lo_q      <= 32'h0;
      retired_q <= '0;
    end else if (wb_stall) begin
      we_q <= we_q;
    end else if (accept) begin
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      retired_q <= retired_q + CNT_W'(1);
      if (mul_we) begin
        hi_q <= MulRes[63:32];
        lo_q <= MulRes[31:0];
      end
      if (hi_we) hi_q <= AluRes;
      if (lo_we) lo_q <= AluRes;
    end else begin
      we_q <= 1'b0;
    end
  end

  assign wb_we    = we_q;
  assign wb_waddr = waddr_q;
  assign wb_wdata = wdata_q;
  assign Hi       = hi_q;
  assign Lo       = lo_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: vector table with a scoreboard queue plus
// hand-written reset, idle and stall sequences.
module tb_wb_stage;

  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Ins, PC4, AluRes, MemData;
  logic [63:0] MulRes;
  logic        wb_stall;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata, Hi, Lo;
  logic [31:0] retired;

  wb_stage #(
    .LINK_REG (5'd31),
    .CNT_W    (32)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Ins      (Ins),
    .PC4      (PC4),
    .AluRes   (AluRes),
    .MemData  (MemData),
    .MulRes   (MulRes),
    .wb_stall (wb_stall),
    .wb_we    (wb_we),
    .wb_waddr (wb_waddr),
    .wb_wdata (wb_wdata),
    .Hi       (Hi),
    .Lo       (Lo),
    .retired  (retired)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] ins, pc4, alu, mem;
    logic [63:0] mul;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata, hi, lo;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata, hi, lo;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ret_exp = 0;

  function automatic vec_t mk(input logic [31:0] ins, pc4, alu, mem, input logic [63:0] mul,
                              input logic we, input logic [4:0] waddr,
                              input logic [31:0] wdata, hi, lo);
    vec_t v;
    v.ins = ins; v.pc4 = pc4; v.alu = alu; v.mem = mem; v.mul = mul;
    v.we = we; v.waddr = waddr; v.wdata = wdata; v.hi = hi; v.lo = lo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, pc4, alu, mem, input logic [63:0] mul,
                       input logic valid);
    Ins = ins; PC4 = pc4; AluRes = alu; MemData = mem; MulRes = mul; in_valid = valid;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " we"}, {63'h0, wb_we}, 64'h0);
    chk({tag, " waddr"}, {59'h0, wb_waddr}, 64'h0);
    chk({tag, " wdata"}, {32'h0, wb_wdata}, 64'h0);
    chk({tag, " hi"}, {32'h0, Hi}, 64'h0);
    chk({tag, " lo"}, {32'h0, Lo}, 64'h0);
    chk({tag, " retired"}, {32'h0, retired}, 64'h0);
  endtask

  initial begin
    exp_t e;
    // Vectors run in order; hi/lo columns track architectural state after each accept
    vecs.push_back(mk(32'h2009_0005, 0, 32'h5, 0, 0, 1, 9, 32'h5, 0, 0));               // ADDI
    vecs.push_back(mk(32'h800A_0001, 0, 32'h1, 32'h12F4_5678, 0, 1, 10, 32'hFFFF_FFF4, 0, 0)); // LB
    vecs.push_back(mk(32'h900A_0001, 0, 32'h1, 32'h12F4_5678, 0, 1, 10, 32'h0000_00F4, 0, 0)); // LBU
    vecs.push_back(mk(32'h940A_0002, 0, 32'h2, 32'h12F4_5678, 0, 1, 10, 32'h0000_5678, 0, 0)); // LHU
    vecs.push_back(mk(32'h840B_0000, 0, 32'h0, 32'h8765_4321, 0, 1, 11, 32'hFFFF_8765, 0, 0)); // LH
    vecs.push_back(mk(32'h8C0C_0003, 0, 32'h3, 32'h12F4_5678, 0, 1, 12, 32'h12F4_5678, 0, 0)); // LW
    vecs.push_back(mk(32'h0022_0018, 0, 0, 0, 64'h0000_0001_8000_0000, 0, 0, 0,
                      32'h1, 32'h8000_0000));                                               // MULT
    vecs.push_back(mk(32'h0000_1810, 0, 0, 0, 0, 1, 3, 32'h1, 32'h1, 32'h8000_0000));       // MFHI
    vecs.push_back(mk(32'h0000_2012, 0, 0, 0, 0, 1, 4, 32'h8000_0000, 32'h1, 32'h8000_0000)); // MFLO
    vecs.push_back(mk(32'h0C10_0004, 32'h0040_0010, 0, 0, 0, 1, 31, 32'h0040_0010,
                      32'h1, 32'h8000_0000));                                               // JAL
    vecs.push_back(mk(32'h0022_0021, 0, 32'h77, 0, 0, 0, 0, 0, 32'h1, 32'h8000_0000));      // ADDU $0
    vecs.push_back(mk(32'h00A0_0011, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0,
                      32'hDEAD_BEEF, 32'h8000_0000));                                       // MTHI
    vecs.push_back(mk(32'h00A0_0013, 0, 32'h0BAD_F00D, 0, 0, 0, 0, 0,
                      32'hDEAD_BEEF, 32'h0BAD_F00D));                                       // MTLO
    vecs.push_back(mk(32'hAC0A_0000, 0, 32'h40, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 32'h0BAD_F00D)); // SW
    vecs.push_back(mk(32'h0100_2809, 32'h0040_0020, 0, 0, 0, 1, 5, 32'h0040_0020,
                      32'hDEAD_BEEF, 32'h0BAD_F00D));                                       // JALR
    vecs.push_back(mk(32'h0022_3023, 0, 32'h1234, 0, 0, 1, 6, 32'h1234,
                      32'hDEAD_BEEF, 32'h0BAD_F00D));                                       // SUBU
    vecs.push_back(mk(32'h1022_0003, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 32'h0BAD_F00D));   // BEQ
    vecs.push_back(mk(32'h0022_0019, 0, 0, 0, 64'hFFFF_FFFE_0000_0001, 0, 0, 0,
                      32'hFFFF_FFFE, 32'h0000_0001));                                       // MULTU
    vecs.push_back(mk(32'h0000_3810, 0, 0, 0, 0, 1, 7, 32'hFFFF_FFFE,
                      32'hFFFF_FFFE, 32'h0000_0001));                                       // MFHI

    // Reset with an instruction presented
    RST = 1'b1; wb_stall = 1'b0;
    drive(32'h2009_0005, 0, 32'h5, 0, 0, 1'b1);
    tick(); tick();
    chk_all_zero("reset");
    chk("reset in_ready", {63'h0, in_ready}, 64'h1);
    RST = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].ins, vecs[i].pc4, vecs[i].alu, vecs[i].mem, vecs[i].mul, 1'b1);
      if (in_valid && !wb_stall) begin
        e.we = vecs[i].we; e.waddr = vecs[i].waddr; e.wdata = vecs[i].wdata;
        e.hi = vecs[i].hi; e.lo = vecs[i].lo;
        sb.push_back(e);
        ret_exp++;
      end
      tick();
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL vec%0d scoreboard: got empty queue expected one entry", i);
      end else begin
        e = sb.pop_front();
        chk($sformatf("vec%0d we", i), {63'h0, wb_we}, {63'h0, e.we});
        if (e.we) begin
          chk($sformatf("vec%0d waddr", i), {59'h0, wb_waddr}, {59'h0, e.waddr});
          chk($sformatf("vec%0d wdata", i), {32'h0, wb_wdata}, {32'h0, e.wdata});
        end
        chk($sformatf("vec%0d hi", i), {32'h0, Hi}, {32'h0, e.hi});
        chk($sformatf("vec%0d lo", i), {32'h0, Lo}, {32'h0, e.lo});
      end
      chk($sformatf("vec%0d retired", i), {32'h0, retired}, {32'h0, ret_exp});
    end

    // Idle cycle: write enable drops, address/data/HI/LO/counter hold
    in_valid = 1'b0;
    tick();
    chk("idle we", {63'h0, wb_we}, 64'h0);
    chk("idle waddr", {59'h0, wb_waddr}, 64'd7);
    chk("idle wdata", {32'h0, wb_wdata}, 64'hFFFF_FFFE);
    chk("idle hi", {32'h0, Hi}, 64'hFFFF_FFFE);
    chk("idle retired", {32'h0, retired}, {32'h0, ret_exp});

    // Stall holds a pending ORI write and blocks the next instruction
    drive(32'h3407_00FF, 0, 32'hFF, 0, 0, 1'b1);
    tick();
    ret_exp++;
    chk("ori we", {63'h0, wb_we}, 64'h1);
    chk("ori waddr", {59'h0, wb_waddr}, 64'd7);
    chk("ori wdata", {32'h0, wb_wdata}, 64'hFF);
    drive(32'h2008_0055, 0, 32'h55, 0, 64'h1234_5678_9ABC_DEF0, 1'b1);
    wb_stall = 1'b1;
    #1;
    chk("stall in_ready", {63'h0, in_ready}, 64'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("stall%0d we", c), {63'h0, wb_we}, 64'h1);
      chk($sformatf("stall%0d waddr", c), {59'h0, wb_waddr}, 64'd7);
      chk($sformatf("stall%0d wdata", c), {32'h0, wb_wdata}, 64'hFF);
      chk($sformatf("stall%0d hi", c), {32'h0, Hi}, 64'hFFFF_FFFE);
      chk($sformatf("stall%0d retired", c), {32'h0, retired}, {32'h0, ret_exp});
    end
    wb_stall = 1'b0;
    #1;
    chk("unstall in_ready", {63'h0, in_ready}, 64'h1);
    tick();
    ret_exp++;
    chk("unstall we", {63'h0, wb_we}, 64'h1);
    chk("unstall waddr", {59'h0, wb_waddr}, 64'd8);
    chk("unstall wdata", {32'h0, wb_wdata}, 64'h55);
    chk("unstall retired", {32'h0, retired}, {32'h0, ret_exp});

    // Mid-stream reset, including over a stall, then first accept
    drive(32'h2009_0005, 0, 32'h5, 0, 0, 1'b1);
    RST = 1'b1; wb_stall = 1'b1;
    tick();
    wb_stall = 1'b0;
    tick();
    chk_all_zero("midreset");
    RST = 1'b0;
    tick();
    chk("post-reset retired", {32'h0, retired}, 64'd1);
    chk("post-reset we", {63'h0, wb_we}, 64'h1);
    chk("post-reset waddr", {59'h0, wb_waddr}, 64'd9);
    chk("post-reset wdata", {32'h0, wb_wdata}, 64'd5);
    in_valid = 1'b0;
    tick();
    chk("final idle we", {63'h0, wb_we}, 64'h0);
    chk("final retired", {32'h0, retired}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
